ibex_multdiv_arbiter: RTL and testbench



---
 rtl/ibex_pkg.sv | 24 ++
 rtl/ibex_multdiv_arb_pick.sv | 26 ++
 rtl/ibex_multdiv_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ibex_multdiv_arbiter.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the multdiv arbiter: operator encoding, arbiter FSM states, sizes.
package ibex_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'b00,
      MD_OP_MULH = 2'b01,
      MD_OP_DIV  = 2'b10,
      MD_OP_REM  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MDARB_IDLE = 2'b00,
      MDARB_BUSY = 2'b01,
      MDARB_DONE = 2'b10
   } mdarb_state_e;

   localparam int unsigned MdArbNumReq = 2;
   localparam int unsigned MdDataW     = 32;

   function automatic logic md_op_is_mult(md_op_e op);
      return (op == MD_OP_MULL) || (op == MD_OP_MULH);
   endfunction

endpackage

// File: rtl/ibex_multdiv_arb_pick.sv
// Two-way winner select: the requester named by prio_i wins a tie.
module ibex_multdiv_arb_pick
   import ibex_pkg::*;
#(
   parameter int unsigned NumReq = MdArbNumReq
) (
   input  logic [NumReq-1:0] req_i,
   input  logic              prio_i,
   output logic [NumReq-1:0] gnt_c,
   output logic              idx_c
);

   always_comb begin
      idx_c = 1'b0;
      gnt_c = '0;
      if (req_i[prio_i]) begin
         idx_c = prio_i;
      end else if (req_i[~prio_i]) begin
         idx_c = ~prio_i;
      end
      if (|req_i) begin
         gnt_c[idx_c] = 1'b1;
      end
   end

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// Shares one multi-cycle multdiv unit between the ID stage (req 0) and the aux port (req 1).
// IBEX_MDARB_RR_EN selects round-robin; when undefined requester 0 has fixed priority.
module ibex_multdiv_arbiter
   import ibex_pkg::*;
#(
   parameter int unsigned NumReq = MdArbNumReq
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [NumReq-1:0]              req_i,
   input  md_op_e                         req_op_i [NumReq],
   input  logic [NumReq-1:0][1:0]         req_signed_mode_i,
   input  logic [NumReq-1:0][MdDataW-1:0] req_op_a_i,
   input  logic [NumReq-1:0][MdDataW-1:0] req_op_b_i,
   input  logic [NumReq-1:0]              kill_i,
   output logic [NumReq-1:0]              gnt_o,
   output logic [NumReq-1:0]              rsp_valid_o,
   input  logic [NumReq-1:0]              rsp_ready_i,
   output logic [MdDataW-1:0]             rsp_result_o,
   output logic                           md_mult_en_o,
   output logic                           md_div_en_o,
   output logic                           md_mult_sel_o,
   output logic                           md_div_sel_o,
   output md_op_e                         md_operator_o,
   output logic [1:0]                     md_signed_mode_o,
   output logic [MdDataW-1:0]             md_op_a_o,
   output logic [MdDataW-1:0]             md_op_b_o,
   output logic                           md_ready_id_o,
   input  logic                           md_valid_i,
   input  logic [MdDataW-1:0]             md_result_i,
   output logic                           busy_o
);

   mdarb_state_e        state_q, state_d;
   logic                owner_q, owner_d;
   md_op_e              op_q, op_d;
   logic [1:0]          mode_q, mode_d;
   logic [MdDataW-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
   logic                mult_en_q, mult_en_d, div_en_q, div_en_d;
   logic [NumReq-1:0]   rsp_valid_q, rsp_valid_d;
   logic [NumReq-1:0]   pick_gnt;
   logic                pick_idx;
   logic                prio;

   ibex_multdiv_arb_pick #(.NumReq(NumReq)) u_pick (
      .req_i  (req_i),
      .prio_i (prio),
      .gnt_c  (pick_gnt),
      .idx_c  (pick_idx)
   );

   // Grant only while IDLE and out of reset, so a DONE->IDLE cycle never grants.
   assign gnt_o = (rst_ni && (state_q == MDARB_IDLE)) ? pick_gnt : '0;

`ifdef IBEX_MDARB_RR_EN
   logic rr_q, rr_d;

   always_comb begin
      rr_d = rr_q;
      if (|gnt_o) begin
         rr_d = ~pick_idx;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

   assign prio = rr_q;
`else
   assign prio = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      op_d        = op_q;
      mode_d      = mode_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      mult_en_d   = mult_en_q;
      div_en_d    = div_en_q;
      rsp_valid_d = rsp_valid_q;
      unique case (state_q)
         MDARB_IDLE: begin
            if (|gnt_o) begin
               owner_d   = pick_idx;
               op_d      = req_op_i[pick_idx];
               mode_d    = req_signed_mode_i[pick_idx];
               a_d       = req_op_a_i[pick_idx];
               b_d       = req_op_b_i[pick_idx];
               mult_en_d = md_op_is_mult(req_op_i[pick_idx]);
               div_en_d  = ~md_op_is_mult(req_op_i[pick_idx]);
               state_d   = MDARB_BUSY;
            end
         end
         MDARB_BUSY: begin
            // Kill beats a same-cycle unit valid; dropping the enables resets the unit.
            if (kill_i[owner_q]) begin
               mult_en_d = 1'b0;
               div_en_d  = 1'b0;
               state_d   = MDARB_IDLE;
            end else if (md_valid_i) begin
               result_d             = md_result_i;
               mult_en_d            = 1'b0;
               div_en_d             = 1'b0;
               rsp_valid_d          = '0;
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = MDARB_DONE;
            end
         end
         MDARB_DONE: begin
            if (kill_i[owner_q] || rsp_ready_i[owner_q]) begin
               rsp_valid_d = '0;
               state_d     = MDARB_IDLE;
            end
         end
         default: begin
            state_d = MDARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= MDARB_IDLE;
         owner_q     <= 1'b0;
         op_q        <= MD_OP_MULL;
         mode_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         mult_en_q   <= 1'b0;
         div_en_q    <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         op_q        <= op_d;
         mode_q      <= mode_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         mult_en_q   <= mult_en_d;
         div_en_q    <= div_en_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign md_mult_en_o     = mult_en_q;
   assign md_div_en_o      = div_en_q;
   assign md_mult_sel_o    = mult_en_q;
   assign md_div_sel_o     = div_en_q;
   assign md_ready_id_o    = mult_en_q | div_en_q;
   assign md_operator_o    = op_q;
   assign md_signed_mode_o = mode_q;
   assign md_op_a_o        = a_q;
   assign md_op_b_o        = b_q;
   assign rsp_valid_o      = rsp_valid_q;
   assign rsp_result_o     = result_q;
   assign busy_o           = (state_q != MDARB_IDLE);

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Scoreboard bench for ibex_multdiv_arbiter with a latency-programmable multdiv unit model.
module tb_ibex_multdiv_arbiter;
   import ibex_pkg::*;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [1:0]       req_i, kill_i, rsp_ready_i;
   md_op_e           req_op_i [2];
   logic [1:0][1:0]  req_signed_mode_i;
   logic [1:0][31:0] req_op_a_i, req_op_b_i;
   logic [1:0]       gnt_o, rsp_valid_o;
   logic [31:0]      rsp_result_o;
   logic             md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o;
   md_op_e           md_operator_o;
   logic [1:0]       md_signed_mode_o;
   logic [31:0]      md_op_a_o, md_op_b_o;
   logic             md_ready_id_o, md_valid_i, busy_o;
   logic [31:0]      md_result_i;

   ibex_multdiv_arbiter dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .req_i             (req_i),
      .req_op_i          (req_op_i),
      .req_signed_mode_i (req_signed_mode_i),
      .req_op_a_i        (req_op_a_i),
      .req_op_b_i        (req_op_b_i),
      .kill_i            (kill_i),
      .gnt_o             (gnt_o),
      .rsp_valid_o       (rsp_valid_o),
      .rsp_ready_i       (rsp_ready_i),
      .rsp_result_o      (rsp_result_o),
      .md_mult_en_o      (md_mult_en_o),
      .md_div_en_o       (md_div_en_o),
      .md_mult_sel_o     (md_mult_sel_o),
      .md_div_sel_o      (md_div_sel_o),
      .md_operator_o     (md_operator_o),
      .md_signed_mode_o  (md_signed_mode_o),
      .md_op_a_o         (md_op_a_o),
      .md_op_b_o         (md_op_b_o),
      .md_ready_id_o     (md_ready_id_o),
      .md_valid_i        (md_valid_i),
      .md_result_i       (md_result_i),
      .busy_o            (busy_o)
   );

   localparam int unsigned OutW = 110;
   logic [OutW-1:0] all_out;
   assign all_out = {gnt_o, rsp_valid_o, rsp_result_o, md_mult_en_o, md_div_en_o,
                     md_mult_sel_o, md_div_sel_o, md_operator_o, md_signed_mode_o,
                     md_op_a_o, md_op_b_o, md_ready_id_o, busy_o};

   typedef struct {
      logic [1:0]  owner;
      logic [31:0] res;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   // Unit model: result valid once the enable has been high for unit_lat cycles.
   int unsigned unit_lat = 0;
   int unsigned unit_cnt;

   function automatic logic [31:0] ref_calc(md_op_e op, logic [1:0] sm, logic [31:0] a, logic [31:0] b);
      logic [63:0] ax, bx, p;
      logic [31:0] q, r;
      ax = {{32{sm[0] & a[31]}}, a};
      bx = {{32{sm[1] & b[31]}}, b};
      p  = ax * bx;
      if (b == 32'd0) begin
         q = '1;
         r = a;
      end else if (sm == 2'b11) begin
         q = 32'($signed(a) / $signed(b));
         r = 32'($signed(a) % $signed(b));
      end else begin
         q = a / b;
         r = a % b;
      end
      case (op)
         MD_OP_MULL: return p[31:0];
         MD_OP_MULH: return p[63:32];
         MD_OP_DIV:  return q;
         default:    return r;
      endcase
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) unit_cnt <= 0;
      else if (md_mult_en_o || md_div_en_o) unit_cnt <= unit_cnt + 1;
      else unit_cnt <= 0;
   end

   always_comb begin
      md_valid_i  = (md_mult_en_o || md_div_en_o) && (unit_cnt >= unit_lat);
      md_result_i = ref_calc(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
   end

   function automatic exp_t pop_exp();
      exp_t e;
      e.owner = 2'b00;
      e.res   = 32'hDEAD_BEEF;
      if (sb.size() > 0) e = sb.pop_front();
      return e;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input logic r, input md_op_e op, input logic [1:0] sm,
                          input logic [31:0] a, input logic [31:0] b);
      req_i[r]             = 1'b1;
      req_op_i[r]          = op;
      req_signed_mode_i[r] = sm;
      req_op_a_i[r]        = a;
      req_op_b_i[r]        = b;
   endtask

   task automatic do_reset();
      req_i       = '0;
      kill_i      = '0;
      rsp_ready_i = '0;
      unit_lat    = 0;
      rst_ni      = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      sb.delete();
   endtask

   task automatic wait_gnt(input int budget, output logic [1:0] g);
      g = '0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (gnt_o != 2'b00) begin
            g = gnt_o;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_rsp(input int budget, output logic [1:0] v, output logic [31:0] res, output int cyc);
      v = '0;
      res = '0;
      cyc = 0;
      for (int i = 0; i < budget; i++) begin
         #1;
         if (rsp_valid_o != 2'b00) begin
            v = rsp_valid_o;
            res = rsp_result_o;
            break;
         end
         tick();
         cyc++;
      end
   endtask

   // Called in the grant cycle: requester drops its request, then waits for the response.
   task automatic finish_op(input logic r, output logic [1:0] v, output logic [31:0] res, output int cyc);
      tick();
      req_i[r] = 1'b0;
      wait_rsp(40, v, res, cyc);
   endtask

   task automatic accept(input logic r);
      rsp_ready_i[r] = 1'b1;
      tick();
      rsp_ready_i = '0;
      #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      set_req(1'b0, MD_OP_DIV, 2'b11, 32'd9, 32'd3);
      set_req(1'b1, MD_OP_MULH, 2'b00, 32'd5, 32'd4);
      #1;
      n_cmp++;
      if (all_out !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      n_cmp++;
      if (md_operator_o !== MD_OP_MULL) begin
         n_err++;
         $display("FAIL reset_operator: got %0d want %0d", md_operator_o, MD_OP_MULL);
      end
      do_reset();
   endtask

   task automatic test_mul();
      logic [1:0] g, v;
      logic [31:0] res;
      int cyc;
      exp_t e;
      do_reset();
      set_req(1'b0, MD_OP_MULL, 2'b00, 32'd7, 32'd6);
      sb.push_back('{owner: 2'b01, res: 32'd42});
      wait_gnt(10, g);
      n_cmp++;
      if (g !== 2'b01) begin n_err++; $display("FAIL mul_gnt: got %b want 01", g); end
      tick();
      req_i[0] = 1'b0;
      #1;
      n_cmp++;
      if ({md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o, busy_o, gnt_o} !== 8'b10101100) begin
         n_err++;
         $display("FAIL mul_enables: got %b want 10101100",
                  {md_mult_en_o, md_div_en_o, md_mult_sel_o, md_div_sel_o, md_ready_id_o, busy_o, gnt_o});
      end
      n_cmp++;
      if ({md_op_a_o, md_op_b_o} !== {32'd7, 32'd6}) begin
         n_err++;
         $display("FAIL mul_operands: got %h/%h want 7/6", md_op_a_o, md_op_b_o);
      end
      wait_rsp(10, v, res, cyc);
      e = pop_exp();
      n_cmp++;
      if (cyc !== 1) begin n_err++; $display("FAIL mul_latency: got %0d want 1", cyc); end
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL mul_rsp: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({rsp_valid_o, rsp_result_o} !== {2'b01, 32'd42}) begin
            n_err++;
            $display("FAIL mul_hold: got %b/%h want 01/0000002a", rsp_valid_o, rsp_result_o);
         end
      end
      accept(1'b0);
      n_cmp++;
      if ({rsp_valid_o, busy_o} !== 3'b000) begin
         n_err++;
         $display("FAIL mul_release: got %b want 000", {rsp_valid_o, busy_o});
      end
   endtask

   task automatic test_simultaneous();
      logic [1:0] g, v, first;
      logic [31:0] res;
      int cyc;
      exp_t e;
`ifdef IBEX_MDARB_RR_EN
      first = 2'b10;
`else
      first = 2'b01;
`endif
      do_reset();
      set_req(1'b0, MD_OP_DIV, 2'b11, 32'd100, 32'd7);
      set_req(1'b1, MD_OP_REM, 2'b11, 32'd100, 32'd7);
      sb.push_back('{owner: 2'b01, res: 32'd14});
      wait_gnt(10, g);
      n_cmp++;
      if (g !== 2'b01) begin n_err++; $display("FAIL sim_gnt0: got %b want 01", g); end
      finish_op(1'b0, v, res, cyc);
      e = pop_exp();
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL sim_rsp_div: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      rsp_ready_i[0] = 1'b1;
      #1;
      n_cmp++;
      if (gnt_o !== 2'b00) begin n_err++; $display("FAIL sim_no_gnt_in_done: got %b want 00", gnt_o); end
      tick();
      rsp_ready_i = '0;
      set_req(1'b0, MD_OP_MULL, 2'b00, 32'd3, 32'd5);
      #1;
      n_cmp++;
      if (gnt_o !== first) begin n_err++; $display("FAIL sim_gnt_pair: got %b want %b", gnt_o, first); end
      if (first == 2'b10) begin
         sb.push_back('{owner: 2'b10, res: 32'd2});
         sb.push_back('{owner: 2'b01, res: 32'd15});
      end else begin
         sb.push_back('{owner: 2'b01, res: 32'd15});
         sb.push_back('{owner: 2'b10, res: 32'd2});
      end
      finish_op(first[1], v, res, cyc);
      e = pop_exp();
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL sim_rsp_first: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      accept(first[1]);
      n_cmp++;
      if (gnt_o !== ~first) begin n_err++; $display("FAIL sim_gnt_second: got %b want %b", gnt_o, ~first); end
      finish_op(~first[1], v, res, cyc);
      e = pop_exp();
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL sim_rsp_second: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      accept(~first[1]);
   endtask

   task automatic test_kill();
      logic [1:0] g, v;
      logic [31:0] res;
      int cyc;
      exp_t e;
      do_reset();
      unit_lat = 20;
      set_req(1'b0, MD_OP_DIV, 2'b11, 32'd100, 32'd7);
      set_req(1'b1, MD_OP_MULL, 2'b00, 32'd9, 32'd9);
      wait_gnt(10, g);
      n_cmp++;
      if (g !== 2'b01) begin n_err++; $display("FAIL kill_gnt: got %b want 01", g); end
      tick();
      req_i[0] = 1'b0;
      tick();
      tick();
      kill_i = 2'b01;
      #1;
      n_cmp++;
      if (md_div_en_o !== 1'b1) begin n_err++; $display("FAIL kill_div_en_before: got %b want 1", md_div_en_o); end
      tick();
      kill_i = 2'b00;
      unit_lat = 0;
      #1;
      n_cmp++;
      if ({md_div_en_o, md_ready_id_o, busy_o, rsp_valid_o} !== 5'b00000) begin
         n_err++;
         $display("FAIL kill_idle: got %b want 00000", {md_div_en_o, md_ready_id_o, busy_o, rsp_valid_o});
      end
      n_cmp++;
      if (gnt_o !== 2'b10) begin n_err++; $display("FAIL kill_next_gnt: got %b want 10", gnt_o); end
      kill_i = 2'b01;
      sb.push_back('{owner: 2'b10, res: 32'd81});
      finish_op(1'b1, v, res, cyc);
      kill_i = 2'b00;
      e = pop_exp();
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL kill_nonowner_rsp: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      accept(1'b1);
   endtask

   task automatic test_hold();
      logic [1:0] g, v;
      logic [31:0] res;
      int cyc;
      exp_t e;
      do_reset();
      unit_lat = 2;
      set_req(1'b0, MD_OP_MULL, 2'b00, 32'h1234, 32'h10);
      sb.push_back('{owner: 2'b01, res: 32'h0001_2340});
      wait_gnt(10, g);
      n_cmp++;
      if (g !== 2'b01) begin n_err++; $display("FAIL hold_gnt: got %b want 01", g); end
      set_req(1'b1, MD_OP_MULL, 2'b00, 32'd2, 32'd3);
      finish_op(1'b0, v, res, cyc);
      e = pop_exp();
      n_cmp++;
      if (cyc !== 3) begin n_err++; $display("FAIL hold_latency: got %0d want 3", cyc); end
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL hold_rsp: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if ({rsp_valid_o, gnt_o, rsp_result_o} !== {2'b01, 2'b00, 32'h0001_2340}) begin
            n_err++;
            $display("FAIL hold_stable: got %b/%b/%h want 01/00/00012340", rsp_valid_o, gnt_o, rsp_result_o);
         end
      end
      accept(1'b0);
      n_cmp++;
      if (gnt_o !== 2'b10) begin n_err++; $display("FAIL hold_gnt_after: got %b want 10", gnt_o); end
      sb.push_back('{owner: 2'b10, res: 32'd6});
      finish_op(1'b1, v, res, cyc);
      e = pop_exp();
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL hold_rsp2: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      kill_i = 2'b10;
      tick();
      kill_i = 2'b00;
      #1;
      n_cmp++;
      if ({rsp_valid_o, busy_o} !== 3'b000) begin
         n_err++;
         $display("FAIL done_kill: got %b want 000", {rsp_valid_o, busy_o});
      end
   endtask

   task automatic test_reset_busy();
      logic [1:0] g, v;
      logic [31:0] res;
      int cyc;
      exp_t e;
      do_reset();
      unit_lat = 20;
      set_req(1'b0, MD_OP_MULL, 2'b00, 32'd5, 32'd5);
      wait_gnt(10, g);
      tick();
      req_i[0] = 1'b0;
      set_req(1'b1, MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2);
      #1;
      n_cmp++;
      if (busy_o !== 1'b1) begin n_err++; $display("FAIL rstb_busy: got %b want 1", busy_o); end
      rst_ni = 1'b0;
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_err++; $display("FAIL rstb_outputs: got %h want 0", all_out); end
      tick();
      tick();
      rst_ni = 1'b1;
      unit_lat = 0;
      sb.push_back('{owner: 2'b10, res: 32'hFFFF_FFFF});
      wait_gnt(10, g);
      n_cmp++;
      if (g !== 2'b10) begin n_err++; $display("FAIL rstb_gnt: got %b want 10", g); end
      finish_op(1'b1, v, res, cyc);
      e = pop_exp();
      n_cmp++;
      if (v !== e.owner || res !== e.res) begin
         n_err++;
         $display("FAIL rstb_mulh: got %b/%h want %b/%h", v, res, e.owner, e.res);
      end
      accept(1'b1);
   endtask

   task automatic test_priority();
      logic [1:0] g, v, want;
      logic [31:0] res;
      int cyc, n_gnt1, want_gnt1;
      exp_t e;
      do_reset();
      n_gnt1 = 0;
      for (int k = 0; k < 4; k++) begin
         set_req(1'b0, MD_OP_MULL, 2'b00, 32'd3, 32'(k + 1));
         set_req(1'b1, MD_OP_MULL, 2'b00, 32'd100, 32'(k + 1));
`ifdef IBEX_MDARB_RR_EN
         want = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
         want = 2'b01;
`endif
         if (want == 2'b01) sb.push_back('{owner: 2'b01, res: 32'(3 * (k + 1))});
         else sb.push_back('{owner: 2'b10, res: 32'(100 * (k + 1))});
         wait_gnt(10, g);
         n_cmp++;
         if (g !== want) begin n_err++; $display("FAIL prio_gnt%0d: got %b want %b", k, g, want); end
         if (g[1]) n_gnt1++;
         finish_op(g[1], v, res, cyc);
         e = pop_exp();
         n_cmp++;
         if (v !== e.owner || res !== e.res) begin
            n_err++;
            $display("FAIL prio_rsp%0d: got %b/%h want %b/%h", k, v, res, e.owner, e.res);
         end
         accept(g[1]);
      end
`ifdef IBEX_MDARB_RR_EN
      want_gnt1 = 2;
`else
      want_gnt1 = 0;
`endif
      n_cmp++;
      if (n_gnt1 !== want_gnt1) begin n_err++; $display("FAIL prio_req1_grants: got %0d want %0d", n_gnt1, want_gnt1); end
      req_i = '0;
   endtask

   initial begin
      req_i = '0;
      kill_i = '0;
      rsp_ready_i = '0;
      req_op_i[0] = MD_OP_MULL;
      req_op_i[1] = MD_OP_MULL;
      req_signed_mode_i = '0;
      req_op_a_i = '0;
      req_op_b_i = '0;
      test_reset();
      test_mul();
      test_simultaneous();
      test_kill();
      test_hold();
      test_reset_busy();
      test_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "bench timeout");
   end

endmodule
